// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the single-cycle-strobe protocol.
// Word-organised storage with byte-write masking; outputs come from registered state only.
module mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_resp,
  output logic              mem_err
);

  localparam int MW = XLEN / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_e;

  state_e            state_q;
  op_e               op_q;
  logic [3:0]        cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic              resp_q;
  logic              err_q;
  logic              err_pend_q;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic [AW-1:0]     idx;
  logic              in_range;
  logic              err_now;
  logic              wr_en;
  logic              strobe;
  op_e               op_new;
  logic              unused_addr;

  assign idx         = mem_addr[AW+1:2];
  assign in_range    = {2'b00, mem_addr[31:2]} < 32'(DEPTH);
  assign err_now     = (op_q == OP_ILL) || !in_range;
  assign wr_en       = (state_q == S_CAPTURE) && (op_q == OP_WR) && in_range;
  assign strobe      = mem_read | mem_write;
  assign unused_addr = ^mem_addr[1:0];

  always_comb begin
    op_new = OP_RD;
    if (mem_read && mem_write) op_new = OP_ILL;
    else if (mem_write)        op_new = OP_WR;
  end

  // Storage is deliberately left out of reset; only the write port touches it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < MW; b++) begin
        if (mem_wmask[b]) mem_q[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_RD;
      cnt_q      <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            op_q    <= op_new;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          err_pend_q <= err_now;
          cnt_q      <= 4'(LATENCY - 1);
          if (err_now)             rdata_q <= '0;
          else if (op_q == OP_RD)  rdata_q <= mem_q[idx];
          if (LATENCY > 1) begin
            state_q <= S_WAIT;
          end else begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            err_q   <= err_now;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            resp_q  <= 1'b1;
            err_q   <= err_pend_q;
          end
        end
        S_RESP: begin
          if (strobe) begin
            op_q    <= op_new;
            state_q <= S_CAPTURE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] rdata0, rdata1;
  logic        resp0, resp1, err0, err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wmask(wmask), .mem_rdata(rdata0), .mem_resp(resp0), .mem_err(err0)
  );

  mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wmask(wmask), .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request; returns in the response cycle (sampled at negedge), lat = cycles after T0.
  task automatic req(input bit sel, input bit now, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     output int lat, output int stray_err);
    if (!now) @(negedge clk);
    addr = a; wdata = d; wmask = m;
    if (sel) begin rd1 = rd; wr1 = wr; end else begin rd0 = rd; wr0 = wr; end
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    lat = -1;
    stray_err = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (sel ? resp1 : resp0) begin
        lat = k;
        break;
      end
      if (sel ? err1 : err0) stray_err++;
    end
  endtask

  task automatic check_pulse_end(input bit sel, input string name);
    @(negedge clk);
    chk({name, "_resp_1cyc"}, 32'(sel ? resp1 : resp0), 32'd0);
    chk({name, "_err_idle"},  32'(sel ? err1 : err0),   32'd0);
  endtask

  initial begin
    int lat, stray, pulses;
    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,       32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h10,       32'h0,        4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDE22BE44};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 1'b0, 32'hDE22BE44};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFF,      32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b1, 32'h20,       32'h01020304, 4'hF, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'hA, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 1'b0, 32'hFF02FF04};
    vecs[12] = '{1'b0, 1'b1, 32'h1004,     32'h12345678, 4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h80000010, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDE22BE44};

    repeat (3) @(negedge clk);
    chk("rst_resp",  32'(resp0), 32'd0);
    chk("rst_err",   32'(err0),  32'd0);
    chk("rst_rdata", rdata0,     32'h0);
    chk("rst_rdata_l1", rdata1,  32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req(1'b0, 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].m, lat, stray);
      chk($sformatf("v%0d_lat", i),   32'(lat),        32'd3);
      chk($sformatf("v%0d_err", i),   32'(err0),       32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rdata0,          vecs[i].exp_rdata);
      chk($sformatf("v%0d_stray_err", i), 32'(stray),  32'd0);
      check_pulse_end(1'b0, $sformatf("v%0d", i));
    end

    // Back-to-back: new strobe issued in the response cycle of the previous request.
    req(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stray);
    chk("b2b_first_lat",   32'(lat), 32'd3);
    chk("b2b_first_rdata", rdata0,   32'hDE22BE44);
    req(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, stray);
    chk("b2b_second_lat",   32'(lat), 32'd3);
    chk("b2b_second_rdata", rdata0,   32'hFF02FF04);
    check_pulse_end(1'b0, "b2b");

    // Strobe during WAIT must be dropped: exactly one pulse.
    @(negedge clk);
    addr = 32'h10; rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    @(negedge clk);
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (resp0) pulses++;
      @(negedge clk);
    end
    chk("wait_ignore_pulses", 32'(pulses), 32'd1);
    chk("wait_ignore_rdata",  rdata0,      32'hDE22BE44);

    // Asynchronous reset while in WAIT.
    @(negedge clk);
    addr = 32'h20; rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    @(negedge clk);
    chk("midrst_pre_rdata", rdata0, 32'hFF02FF04);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp",  32'(resp0), 32'd0);
    chk("midrst_err",   32'(err0),  32'd0);
    chk("midrst_rdata", rdata0,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp0) pulses++;
    end
    chk("midrst_dropped", 32'(pulses), 32'd0);
    addr = 32'h10;
    req(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stray);
    chk("postrst_lat",   32'(lat), 32'd3);
    chk("postrst_err",   32'(err0), 32'd0);
    chk("postrst_rdata", rdata0,   32'hDE22BE44);
    check_pulse_end(1'b0, "postrst");

    // LATENCY=1 instance: response two cycles after the strobe.
    req(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h5A5AA5A5, 4'hF, lat, stray);
    chk("l1_wr_lat",   32'(lat),  32'd2);
    chk("l1_wr_err",   32'(err1), 32'd0);
    chk("l1_wr_rdata", rdata1,    32'h0);
    check_pulse_end(1'b1, "l1_wr");
    req(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, stray);
    chk("l1_rd_lat",   32'(lat),  32'd2);
    chk("l1_rd_err",   32'(err1), 32'd0);
    chk("l1_rd_rdata", rdata1,    32'h5A5AA5A5);
    check_pulse_end(1'b1, "l1_rd");
    req(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, lat, stray);
    chk("l1_err_lat",   32'(lat),  32'd2);
    chk("l1_err_err",   32'(err1), 32'd1);
    chk("l1_err_rdata", rdata1,    32'h0);
    check_pulse_end(1'b1, "l1_err");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
